clk_gate_ctrl: RTL
==================

# clk_gate_ctrl

Per-domain clock-gating controller that produces the registered enable consumed by `clk_gater_ul` (its `clkEn_i`). It watches the domain's pending-work indicator and, after a programmable idle window and a drain handshake with the gated logic, drops the enable. On renewed demand it restores the clock and holds `ready_o` low for a settle window before work may resume. One instance sits next to each `clk_gater_ul` in the core's gated-domain wrappers.

## Interface
- `IDLE_CYCLES`, 16: consecutive idle cycles in RUN before a sleep request is raised; legal range 1..255.
- `WAKE_CYCLES`, 2: cycles with clock enabled but `ready_o` low after leaving OFF; legal range 0..255.
- `clk_i` in 1: ungated clock; the same net drives `clk_gater_ul.clk_i`.
- `resetN_i` in 1: synchronous, active-low reset.
- `activity_i` in 1: domain has pending work this cycle.
- `wakeReq_i` in 1: early wake hint from upstream; ignored outside OFF.
- `forceOn_i` in 1: debug/override; keeps the clock on and blocks or aborts gating.
- `sleepAck_i` in 1: gated logic is drained and safe to stop; sampled only in REQ.
- `clkEn_o` out 1: registered gate enable to `clk_gater_ul.clkEn_i`.
- `ready_o` out 1: domain may accept work.
- `sleepReq_o` out 1: request to the gated logic to drain.
- `gatedCycles_o` out 32 and `gateEvents_o` out 16: present only with `CLK_GATE_STATS_EN`.

## Operation
- Reset (`resetN_i`=0 at a rising edge): state RUN, `clkEn_o`=1 (the domain must be clocked to see its own reset), `ready_o`=1, `sleepReq_o`=0, idle and wake counters 0, stats 0. Reset takes priority over every other input in every state.
- RUN (`clkEn_o`=1, `ready_o`=1, `sleepReq_o`=0):
  - `activity_i`=1 or `forceOn_i`=1 clears the idle counter.
  - Otherwise the idle counter increments, saturating at `IDLE_CYCLES`.
  - Move to REQ on the edge where the counter would reach `IDLE_CYCLES`.
- REQ (`clkEn_o`=1, `ready_o`=1, `sleepReq_o`=1):
  - `activity_i`=1 or `forceOn_i`=1 moves to RUN and clears the idle counter. Activity wins over a simultaneous `sleepAck_i`.
  - Otherwise `sleepAck_i`=1 moves to OFF.
  - Otherwise stay in REQ. There is no timeout.
- OFF (`clkEn_o`=0, `ready_o`=0, `sleepReq_o`=0):
  - Any of `activity_i`, `wakeReq_i`, `forceOn_i` moves to WAKE and loads the wake counter with 0.
  - If `WAKE_CYCLES`=0, the move goes straight to RUN instead.
- WAKE (`clkEn_o`=1, `ready_o`=0, `sleepReq_o`=0):
  - The wake counter increments each cycle.
  - Move to RUN on the edge where it reaches `WAKE_CYCLES`, clearing the idle counter.
  - Inputs are ignored. A wake is never aborted back to OFF.
- All outputs are registered and decoded from next-state. Nothing is combinational from the inputs.
- Counter widths are 8 bits. Comparisons are unsigned.

## Timing
- Idle to request: with `activity_i` low from cycle 0, `sleepReq_o` rises after edge `IDLE_CYCLES`.
- Acknowledge to gate: `sleepAck_i` sampled high at edge N means `clkEn_o`=0 after edge N. The ICG latch then blocks the following high phase.
- Wake: demand sampled at edge N gives:
  - `clkEn_o`=1 after edge N;
  - `ready_o`=1 after edge N+`WAKE_CYCLES`+1;
  - for `WAKE_CYCLES`=0, `clkEn_o` and `ready_o` both rise after edge N.
- `clkEn_o` changes only on rising `clk_i`. This satisfies the low-transparent latch's setup requirement.
- Reset asserted mid-WAKE or mid-OFF: `clkEn_o` returns to 1 after the reset edge.

## Configuration
- `CLK_GATE_STATS_EN` defined:
  - `gatedCycles_o` counts cycles spent in OFF, saturating at 2^32-1.
  - `gateEvents_o` counts REQ→OFF transitions, saturating at 2^16-1.
  - Both counters clear on reset.
- `CLK_GATE_STATS_EN` undefined: both ports and their counters are absent. FSM behaviour is identical in both builds.

## Structure
- Shared package `clk_gate_pkg` holds:
  - the `clk_gate_state_t` enum (RUN, REQ, OFF, WAKE);
  - `CLK_GATE_CNT_W`=8;
  - the stats widths 32 and 16.
- One sub-module, `sat_counter`, is parameterised by width and has clear/increment inputs. It is instantiated for the idle counter, the wake counter and, when the macro is defined, the two stats counters.

## Test plan
- **Reset:** hold `resetN_i`=0 for 3 cycles with random inputs → `clkEn_o`=1, `ready_o`=1, `sleepReq_o`=0 throughout and one cycle after release.
- **Gate:** `IDLE_CYCLES`=16, `activity_i`=0 → `sleepReq_o` rises after edge 16. Then `sleepAck_i`=1 at edge 20 → `clkEn_o`=0 after edge 20 and `gateEvents_o`=1.
- **Abort:** in REQ, drive `activity_i`=1 and `sleepAck_i`=1 in the same cycle → state returns to RUN, `clkEn_o` stays 1, and the idle count restarts so the next request comes 16 idle cycles later.
- **Wake:** `WAKE_CYCLES`=2, OFF, `wakeReq_i` pulse at edge N → `clkEn_o`=1 after N and `ready_o`=1 after N+3. With `WAKE_CYCLES`=0 → both rise after N.
- **Force:** `forceOn_i`=1 held for 100 idle cycles → `sleepReq_o` never asserts. Asserting `forceOn_i` in OFF → wakes as in the Wake scenario.
- **Stats and reset mid-OFF:** stay in OFF for 50 cycles → `gatedCycles_o`=50. Then `resetN_i`=0 for 1 cycle → `clkEn_o`=1 and `gatedCycles_o`=0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and widths for the per-domain clock-gating controller.
// The optional statistics counters are enabled with CLK_GATE_STATS_EN.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        OFF  = 2'd2,
        WAKE = 2'd3
    } clk_gate_state_t;

    localparam int CLK_GATE_CNT_W    = 8;
    localparam int CLK_GATE_GATED_W  = 32;
    localparam int CLK_GATE_EVENTS_W = 16;

endpackage

// File: rtl/clk_gate_ctrl_sat_counter.sv
// Saturating up-counter with clear and increment; clear wins over increment.
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_r;

    // Count register: synchronous reset, clear, saturating increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX)) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller producing the registered enable for clk_gater_ul.
// Define CLK_GATE_STATS_EN to add the gated-cycle and gate-event counters.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic resetN_i,
    input  logic activity_i,
    input  logic wakeReq_i,
    input  logic forceOn_i,
    input  logic sleepAck_i,
    output logic clkEn_o,
    output logic ready_o,
    output logic sleepReq_o
`ifdef CLK_GATE_STATS_EN
    ,
    output logic [CLK_GATE_GATED_W-1:0]  gatedCycles_o,
    output logic [CLK_GATE_EVENTS_W-1:0] gateEvents_o
`endif
);

    localparam logic [CLK_GATE_CNT_W-1:0] IDLE_MAX = CLK_GATE_CNT_W'(IDLE_CYCLES);
    localparam logic [CLK_GATE_CNT_W-1:0] WAKE_MAX = CLK_GATE_CNT_W'(WAKE_CYCLES);
    localparam logic [CLK_GATE_CNT_W:0]   IDLE_HIT = (CLK_GATE_CNT_W + 1)'(IDLE_CYCLES);

    clk_gate_state_t state_r;
    clk_gate_state_t next_state_s;
    logic clk_en_r;
    logic ready_r;
    logic sleep_req_r;

    logic busy_s;
    logic demand_s;
    logic idle_hit_s;
    logic wake_done_s;
    logic idle_clr_s;
    logic idle_inc_s;
    logic wake_clr_s;
    logic wake_inc_s;
    logic [CLK_GATE_CNT_W-1:0] idle_cnt_s;
    logic [CLK_GATE_CNT_W-1:0] wake_cnt_s;

    assign busy_s      = activity_i | forceOn_i;
    assign demand_s    = busy_s | wakeReq_i;
    assign idle_hit_s  = (({1'b0, idle_cnt_s} + {{CLK_GATE_CNT_W{1'b0}}, 1'b1}) == IDLE_HIT);
    assign wake_done_s = (wake_cnt_s == WAKE_MAX);

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RUN: begin
                if (!busy_s && idle_hit_s) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = RUN;
                end
            end
            REQ: begin
                if (busy_s) begin
                    next_state_s = RUN;
                end else if (sleepAck_i) begin
                    next_state_s = OFF;
                end else begin
                    next_state_s = REQ;
                end
            end
            OFF: begin
                if (demand_s) begin
                    next_state_s = (WAKE_CYCLES == 0) ? RUN : WAKE;
                end else begin
                    next_state_s = OFF;
                end
            end
            WAKE: begin
                if (wake_done_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = WAKE;
                end
            end
            default: next_state_s = RUN;
        endcase
    end

    // Counter controls: idle count restarts on every entry into RUN
    always_comb begin
        idle_clr_s = 1'b0;
        idle_inc_s = 1'b0;
        if (state_r == RUN) begin
            idle_clr_s = busy_s;
            idle_inc_s = ~busy_s;
        end else begin
            idle_clr_s = (next_state_s == RUN);
            idle_inc_s = 1'b0;
        end
        wake_clr_s = (state_r != WAKE);
        wake_inc_s = (state_r == WAKE);
    end

    // State and outputs registered from the next-state decode
    always_ff @(posedge clk_i) begin
        if (!resetN_i) begin
            state_r     <= RUN;
            clk_en_r    <= 1'b1;
            ready_r     <= 1'b1;
            sleep_req_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            clk_en_r    <= (next_state_s != OFF);
            ready_r     <= (next_state_s == RUN) || (next_state_s == REQ);
            sleep_req_r <= (next_state_s == REQ);
        end
    end

    assign clkEn_o    = clk_en_r;
    assign ready_o    = ready_r;
    assign sleepReq_o = sleep_req_r;

    sat_counter #(.WIDTH(CLK_GATE_CNT_W), .MAX(IDLE_MAX)) u_idle_cnt (
        .clk   (clk_i),
        .rst_n (resetN_i),
        .clr   (idle_clr_s),
        .inc   (idle_inc_s),
        .cnt   (idle_cnt_s)
    );

    sat_counter #(.WIDTH(CLK_GATE_CNT_W), .MAX(WAKE_MAX)) u_wake_cnt (
        .clk   (clk_i),
        .rst_n (resetN_i),
        .clr   (wake_clr_s),
        .inc   (wake_inc_s),
        .cnt   (wake_cnt_s)
    );

`ifdef CLK_GATE_STATS_EN
    logic gated_inc_s;
    logic event_inc_s;

    assign gated_inc_s = (state_r == OFF);
    assign event_inc_s = (state_r == REQ) && (next_state_s == OFF);

    sat_counter #(.WIDTH(CLK_GATE_GATED_W)) u_gated_cnt (
        .clk   (clk_i),
        .rst_n (resetN_i),
        .clr   (1'b0),
        .inc   (gated_inc_s),
        .cnt   (gatedCycles_o)
    );

    sat_counter #(.WIDTH(CLK_GATE_EVENTS_W)) u_event_cnt (
        .clk   (clk_i),
        .rst_n (resetN_i),
        .clr   (1'b0),
        .inc   (event_inc_s),
        .cnt   (gateEvents_o)
    );
`endif

endmodule
